// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine host.
// Pure declarations: no logic, no latency, no flow control.
package conv_pkg;
    localparam int DW     = 20;
    localparam int IMG_AW = 12;
    localparam int L1_AW  = 10;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    localparam int ERR_CSEL    = 0;
    localparam int ERR_BUSY    = 1;
    localparam int ERR_TIMEOUT = 2;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;
endpackage

// File: rtl/conv_layer_ram.sv
// Word-wide RAM: one synchronous write port, N_RD asynchronous read ports.
// Write lands at the clock edge; reads are zero-latency. No backpressure.
module conv_layer_ram #(
    parameter int W     = 20,
    parameter int AW    = 12,
    parameter int DEPTH = 1 << AW,
    parameter int N_RD  = 1
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [W-1:0]              wdata,
    input  logic [N_RD-1:0][AW-1:0]   raddr,
    output logic [N_RD-1:0][W-1:0]    rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read returns pre-write contents on a same-cycle collision.
    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            rdata[i] = mem[raddr[i]];
        end
    end
endmodule

// File: rtl/conv_host.sv
// Memory-side host for the conv engine: image load, layer memory service, L1 result dump.
// Reads are combinational; writes land on the clock edge; the dump stalls on out_ready.
module conv_host
    import conv_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              img_valid,
    input  logic [DW-1:0]     img_data,
    output logic              img_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    input  logic [2:0]        csel,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [L1_AW-1:0]  out_addr,
    output logic              out_last,
    input  logic              out_ready,
    output logic              done,
    output logic [2:0]        err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [IMG_AW-1:0]  wcnt_q, wcnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [L1_AW-1:0]   rcnt_q, rcnt_d;
    logic [2:0]         err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q;

    logic               img_hs;
    logic               wr_l0, wr_l1, wr_bad;
    logic               l1_wr_in_range, l1_rd_in_range;
    logic [DW-1:0]      l0_rdata;
    logic [1:0][DW-1:0] l1_rdata;

    assign img_hs         = (state_q == ST_LOAD) && img_valid;
    assign l1_wr_in_range = (caddr_wr[IMG_AW-1:L1_AW] == '0);
    assign l1_rd_in_range = (caddr_rd[IMG_AW-1:L1_AW] == '0);
    assign wr_l0          = cwr && (csel == CSEL_L0);
    assign wr_l1          = cwr && (csel == CSEL_L1) && l1_wr_in_range;
    assign wr_bad         = cwr && !wr_l0 && !wr_l1;

    conv_layer_ram #(.W(DW), .AW(IMG_AW), .N_RD(1)) u_img (
        .clk   (clk),
        .we    (img_hs),
        .waddr (wcnt_q),
        .wdata (img_data),
        .raddr (iaddr),
        .rdata (idata)
    );

    conv_layer_ram #(.W(DW), .AW(IMG_AW), .N_RD(1)) u_l0 (
        .clk   (clk),
        .we    (wr_l0),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (caddr_rd),
        .rdata (l0_rdata)
    );

    // Port 0 serves the engine, port 1 feeds the result dump.
    conv_layer_ram #(.W(DW), .AW(L1_AW), .N_RD(2)) u_l1 (
        .clk   (clk),
        .we    (wr_l1),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr ({rcnt_q, caddr_rd[L1_AW-1:0]}),
        .rdata (l1_rdata)
    );

    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (csel == CSEL_L0) begin
                cdata_rd = l0_rdata;
            end else if ((csel == CSEL_L1) && l1_rd_in_range) begin
                cdata_rd = l1_rdata[0];
            end
        end
    end

    assign out_data = l1_rdata[1];
    assign out_addr = rcnt_q;
    assign done     = done_q;
    assign err      = err_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        tcnt_d    = tcnt_q;
        rcnt_d    = rcnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        img_ready = 1'b0;
        ready     = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        if (wr_bad) begin
            err_d[ERR_CSEL] = 1'b1;
        end
        // A busy rise is only legitimate as the response to ready.
        if (busy && !busy_q && (state_q != ST_READY)) begin
            err_d[ERR_BUSY] = 1'b1;
        end

        unique case (state_q)
            ST_LOAD: begin
                img_ready = 1'b1;
                if (img_valid) begin
                    wcnt_d = wcnt_q + IMG_AW'(1);
                    if (wcnt_q == '1) begin
                        state_d = ST_READY;
                        tcnt_d  = '0;
                    end
                end
            end
            ST_READY: begin
                ready  = 1'b1;
                tcnt_d = tcnt_q + TW'(1);
                if (busy) begin
                    state_d = ST_RUN;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (busy_q && !busy) begin
                    state_d = ST_DUMP;
                    rcnt_d  = '0;
                end
            end
            ST_DUMP: begin
                out_valid = 1'b1;
                out_last  = (rcnt_q == '1);
                if (out_ready) begin
                    rcnt_d = rcnt_q + L1_AW'(1);
                    if (rcnt_q == '1) begin
                        done_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            rcnt_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            rcnt_q  <= rcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy;
        end
    end
endmodule

// File: tb/tb_conv_host.sv
// Directed bench for conv_host: load, run, layer access, dump, timeout, mid-dump reset.
module tb_conv_host;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              img_valid = 1'b0;
    logic [DW-1:0]     img_data = '0;
    logic              img_ready;
    logic              ready;
    logic              busy = 1'b0;
    logic [IMG_AW-1:0] iaddr = '0;
    logic [DW-1:0]     idata;
    logic              cwr = 1'b0;
    logic [IMG_AW-1:0] caddr_wr = '0;
    logic [DW-1:0]     cdata_wr = '0;
    logic              crd = 1'b0;
    logic [IMG_AW-1:0] caddr_rd = '0;
    logic [DW-1:0]     cdata_rd;
    logic [2:0]        csel = 3'b000;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [L1_AW-1:0]  out_addr;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic              done;
    logic [2:0]        err;

    int nerr = 0;
    int nchecks = 0;
    int idx;
    logic [DW-1:0] l1_model [1024];

    conv_host #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .img_valid (img_valid),
        .img_data  (img_data),
        .img_ready (img_ready),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image();
        img_valid = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            img_data = DW'(i);
            if (i == 4095) chk("ready_low_before_last", ready, 0);
            tick();
        end
        img_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < 1024; j++) begin
            l1_model[j] = (j == 1023) ? 20'h12345 : DW'(j * 613 + 7);
        end

        // Reset values
        #1;
        chk("rst_outputs", {ready, out_valid, out_last, done, err, img_ready},
            {1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1});
        chk("rst_cdata_rd", cdata_rd, 0);
        #20;
        reset = 1'b1;

        // Image load, ready rises right after word 4095
        load_image();
        chk("ready_after_load", {ready, img_ready, err}, {1'b1, 1'b0, 3'b000});
        iaddr = 12'h041;
        #1;
        chk("idata_41", idata, 20'h00041);
        iaddr = 12'hFFF;
        #1;
        chk("idata_fff", idata, 20'h00FFF);

        // Start the engine 3 cycles after ready
        tick(); tick(); tick();
        chk("ready_held", ready, 1);
        busy = 1'b1;
        tick();
        chk("run_entry", {ready, img_ready, out_valid, err}, {1'b0, 1'b0, 1'b0, 3'b000});

        // L0 write then read-back, and same-cycle read/write collision
        csel = CSEL_L0; cwr = 1'b1; caddr_wr = 12'h123; cdata_wr = 20'hABCDE;
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h123;
        #1;
        chk("l0_readback", cdata_rd, 20'hABCDE);
        cwr = 1'b1; cdata_wr = 20'h11111;
        #1;
        chk("l0_collision_old", cdata_rd, 20'hABCDE);
        tick();
        cwr = 1'b0;
        #1;
        chk("l0_new_value", cdata_rd, 20'h11111);

        // Bad bank select drops the write and flags err[0]
        csel = 3'b010; cwr = 1'b1; cdata_wr = 20'h22222;
        #1;
        chk("badsel_read_zero", cdata_rd, 0);
        tick();
        cwr = 1'b0;
        chk("err_csel", err, 3'b001);
        csel = CSEL_L0;
        #1;
        chk("l0_write_dropped", cdata_rd, 20'h11111);
        crd = 1'b0;
        #1;
        chk("crd_low_zero", cdata_rd, 0);

        // Fill L1 during RUN
        csel = CSEL_L1; cwr = 1'b1;
        for (int j = 0; j < 1024; j++) begin
            caddr_wr = 12'(j);
            cdata_wr = l1_model[j];
            tick();
        end
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h3FF;
        #1;
        chk("l1_rd_3ff", cdata_rd, 20'h12345);
        caddr_rd = 12'h005;
        #1;
        chk("l1_rd_005", cdata_rd, l1_model[5]);
        crd = 1'b0;
        chk("no_valid_in_run", out_valid, 0);

        // Busy falls: dump with out_ready toggling every other cycle
        busy = 1'b0;
        tick();
        idx = 0;
        for (int c = 0; c < 4096 && idx < 1024; c++) begin
            out_ready = c[0];
            #1;
            chk("dump_word", {out_valid, out_last, out_addr, out_data, done},
                {1'b1, (idx == 1023), 10'(idx), l1_model[idx], 1'b0});
            tick();
            if (out_ready) idx++;
        end
        out_ready = 1'b0;
        chk("dump_count", idx, 1024);
        chk("done_pulse", {done, out_valid, img_ready}, {1'b1, 1'b0, 1'b1});
        tick();
        chk("done_single", done, 0);

        // No busy after load: timeout after 16 cycles in READY
        load_image();
        chk("ready_again", ready, 1);
        repeat (15) tick();
        chk("ready_before_timeout", {ready, err[2]}, 2'b10);
        tick();
        chk("timeout", {ready, img_ready, err}, {1'b0, 1'b1, 3'b101});

        // Reset in the middle of a dump
        load_image();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (500) tick();
        chk("dump_at_500", {out_valid, out_addr, out_data}, {1'b1, 10'd500, l1_model[500]});
        reset = 1'b0;
        #1;
        chk("reset_mid_dump", {out_valid, ready, done, err, img_ready},
            {1'b0, 1'b0, 1'b0, 3'b000, 1'b1});
        out_ready = 1'b0;
        #3;
        reset = 1'b1;
        img_valid = 1'b1; img_data = 20'h0ABCD;
        tick();
        img_data = 20'h01234;
        tick();
        img_valid = 1'b0;
        iaddr = 12'h000;
        #1;
        chk("reload_addr0", idata, 20'h0ABCD);
        iaddr = 12'h001;
        #1;
        chk("reload_addr1", idata, 20'h01234);
        iaddr = 12'h002;
        #1;
        chk("image_not_cleared", idata, 20'h00002);

        // Busy rising while loading flags err[1] but leaves state alone
        busy = 1'b1;
        tick();
        busy = 1'b0;
        chk("err_busy_in_load", {err, img_ready, ready}, {3'b010, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/conv_host.md
# conv_host

Memory-side responder for the convolution/max-pool engine. It loads a 64x64 image over a valid/ready stream and raises `ready` to start the engine. While the engine runs, it serves image reads and layer-memory reads and writes. When the engine drops `busy`, it streams the 32x32 layer-1 result out. It sits between the system data path and the engine, owning the image, L0 and L1 memories.

## Interface
- `DW`, 20: data word width (signed fixed point, 4.16).
- `IMG_AW`, 12: image / L0 address width (4096 words).
- `L1_AW`, 10: L1 address width (1024 words).
- `TIMEOUT`, 1024: cycles allowed between `ready` rise and `busy` rise.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `img_valid` in 1: image word offered.
- `img_data` in DW: image word, raster order.
- `img_ready` out 1: image word accepted when `img_valid & img_ready`.
- `ready` out 1: image loaded; start request to the engine.
- `busy` in 1: engine running.
- `iaddr` in 12: image read address.
- `idata` out DW: image word at `iaddr`.
- `cwr` in 1: layer write strobe.
- `caddr_wr` in 12: layer write address.
- `cdata_wr` in DW: layer write data.
- `crd` in 1: layer read strobe.
- `caddr_rd` in 12: layer read address.
- `cdata_rd` out DW: layer read data.
- `csel` in 3: bank select (001 = L0, 011 = L1).
- `out_valid` out 1: result word valid.
- `out_data` out DW: L1 word.
- `out_addr` out L1_AW: L1 index of `out_data`.
- `out_last` out 1: asserted with index 1023.
- `out_ready` in 1: downstream accept.
- `done` out 1: one-cycle pulse after the last result handshake.
- `err` out 3: sticky flags. [0] bad `csel` or out-of-range L1 write; [1] `busy` rose outside READY; [2] timeout.

## Operation
- FSM states: LOAD, READY, RUN, DUMP.
- Reset enters LOAD. Memory contents are not cleared.
- LOAD:
  - `img_ready` = 1.
  - Each handshake writes `img_data` to image[wcnt] and increments the 12-bit `wcnt`.
  - The handshake that accepts word 4095 moves to READY; `wcnt` wraps to 0.
- READY:
  - `ready` = 1, counter `tcnt` increments.
  - `busy` sampled high moves to RUN and clears `ready`.
  - `tcnt` == TIMEOUT sets err[2] and returns to LOAD.
- RUN:
  - `idata` = image[`iaddr`], asynchronous read. Addresses wrap modulo 4096 with no error; the engine masks edge pixels itself.
  - Write on a `clk` edge with `cwr` = 1:
    - `csel` 001 → L0[`caddr_wr`].
    - `csel` 011 with `caddr_wr[11:10]` = 0 → L1[`caddr_wr[9:0]`].
    - Anything else: write dropped, err[0] set.
  - `cdata_rd` = selected bank at `caddr_rd` when `crd` = 1, else 0. Asynchronous read. A bad `csel` returns 0.
  - Read and write to the same location in the same cycle: `cdata_rd` returns the old contents.
  - `busy` high→low (registered previous value = 1, current = 0) moves to DUMP with `rcnt` = 0.
- DUMP:
  - `out_valid` = 1, `out_data` = L1[`rcnt`], `out_addr` = `rcnt`, `out_last` = (`rcnt` == 1023).
  - `rcnt` advances only on `out_valid & out_ready`; data is held stable while stalled.
  - The last handshake pulses `done` and returns to LOAD.
- `busy` rising in LOAD or DUMP sets err[1]. State is unchanged and layer writes are still honoured.
- Reset mid-operation: FSM, `ready`, `done`, `err` and all counters clear immediately.

## Timing
- Reset values:
  - `ready`, `out_valid`, `out_last`, `done` = 0; `err` = 0.
  - `idata` and `cdata_rd` follow the combinational rules (`cdata_rd` = 0 while `crd` = 0).
  - `img_ready` = 1, since reset enters LOAD.
- `ready` rises the cycle after the 4096th image handshake. It falls the cycle after `busy` is first sampled high.
- Image and layer reads are zero-latency (combinational). The engine samples read data one edge after presenting the address.
- Layer writes take effect at the `clk` edge where `cwr` = 1; they are visible to a read the following cycle.
- The first `out_valid` is the cycle after the `busy` fall is detected. With `out_ready` held high, the dump takes 1024 cycles and `done` pulses on the cycle after the final handshake.

## Structure
- Shared package `conv_pkg`:
  - `DW`, `IMG_AW`, `L1_AW`.
  - `CSEL_L0` = 3'b001, `CSEL_L1` = 3'b011.
  - The FSM state encoding.
  - `ERR_*` bit indices.
- One sub-module, `conv_layer_ram`: parameterised depth/width, synchronous write, asynchronous read. It is instantiated three times: image, L0, L1.

## Test plan
- Load 4096 words equal to their index → `ready` rises the cycle after the last handshake; `iaddr` = 0x0041 returns `idata` = 0x00041.
- Raise `busy` 3 cycles after `ready` → `ready` falls the next cycle; state RUN; no error bits set.
- Write `cwr`, `csel` = 001, addr 0x123, data 0xABCDE; read back with `crd` the next cycle → `cdata_rd` = 0xABCDE. The same access with `csel` = 010 → write dropped, err[0] = 1.
- Write L1[1023] = 0x12345, drop `busy`, toggle `out_ready` every other cycle → 1024 words in order; `out_last` only with `out_addr` = 1023 and `out_data` = 0x12345; `done` pulses once.
- Never assert `busy` after load with TIMEOUT = 16 → err[2] = 1 after 16 cycles; `ready` = 0; `img_ready` = 1.
- Assert `reset` low mid-dump at `rcnt` = 500 → `out_valid` = 0 immediately; the next load restarts at image address 0.
